// File: rtl/bcd_split_ctrl.sv
// Binary-to-BCD splitter: repeated divide-by-DIVISOR through the shared `div` unit.
// Define LEADING_ZERO_BLANK_EN to replace leading zero digits with the blank code 4'hF.
module bcd_split_ctrl #(
  parameter int NUM_DIGITS = 5,
  parameter int DIVISOR    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             value,
  output logic                    busy,
  output logic                    valid,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    div_init,
  output logic [15:0]             div_op_A,
  output logic [15:0]             div_op_B,
  input  logic                    div_done,
  input  logic [31:0]             div_result
);

  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ISSUE,
    WAIT,
    STORE,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [KW-1:0]           k;
  logic [15:0]             work;
  logic [15:0]             q;
  logic                    done_q;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] assembled;
  logic [3:0]              rem_digit;
  logic                    last_digit;
  logic                    done_rise;
  logic                    unused_result_hi;

  function automatic logic [15:0] times_divisor(input logic [15:0] x);
    if (DIVISOR == 10) return (x << 3) + (x << 1);
    else               return 16'(x * DIVISOR);
  endfunction

  function automatic logic [3:0] remainder(input logic [15:0] w, input logic [15:0] quo);
    logic [15:0] r;
    r = w - times_divisor(quo);
    return r[3:0];
  endfunction

  function automatic logic [4*NUM_DIGITS-1:0] present(input logic [4*NUM_DIGITS-1:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    logic [4*NUM_DIGITS-1:0] r;
    logic                    lead;
    r    = d;
    lead = 1'b1;
    // Digit 0 is excluded so a zero value still shows a single 0.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && d[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else                             lead = 1'b0;
    end
    return r;
`else
    return d;
`endif
  endfunction

  assign div_op_B         = 16'(DIVISOR);
  assign unused_result_hi = ^div_result[31:16];

  assign busy       = (state != IDLE);
  assign valid      = (state == DONE);
  assign div_init   = (state == ISSUE);
  assign last_digit = (k == KW'(NUM_DIGITS - 1));
  assign done_rise  = div_done && !done_q;
  assign rem_digit  = remainder(work, q);

  always_comb begin
    assembled = shadow;
    assembled[4*k +: 4] = rem_digit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = DRAIN;
      // The divider keeps done high long after a result; a new init is only seen once it drops.
      DRAIN: if (!div_done) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT:  if (done_rise) state_next = STORE;
      STORE: state_next = last_digit ? DONE : DRAIN;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k        <= '0;
      work     <= '0;
      q        <= '0;
      done_q   <= 1'b0;
      shadow   <= '0;
      digits   <= '0;
      div_op_A <= '0;
    end else begin
      done_q <= div_done;
      if (state == IDLE && start) begin
        work <= value;
        k    <= '0;
      end
      if (state == DRAIN && !div_done) div_op_A <= work;
      if (state == WAIT && done_rise) q <= div_result[15:0];
      if (state == STORE) begin
        shadow <= assembled;
        work   <= q;
        // Digits change only once, so the display never shows a half-finished conversion.
        if (last_digit) digits <= present(assembled);
        else            k      <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_split_ctrl.sv
// Scoreboard bench for bcd_split_ctrl with a behavioural multi-cycle divider that holds done high.
module tb_bcd_split_ctrl;

  localparam int ND = 5;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [19:0] E_12345 = 20'h12345;
  localparam logic [19:0] E_65535 = 20'h65535;
  localparam logic [19:0] E_0     = 20'hFFFF0;
  localparam logic [19:0] E_7     = 20'hFFFF7;
  localparam logic [19:0] E_1005  = 20'hF1005;
  localparam logic [19:0] E_40960 = 20'h40960;
  localparam logic [19:0] E_42    = 20'hFFF42;
`else
  localparam logic [19:0] E_12345 = 20'h12345;
  localparam logic [19:0] E_65535 = 20'h65535;
  localparam logic [19:0] E_0     = 20'h00000;
  localparam logic [19:0] E_7     = 20'h00007;
  localparam logic [19:0] E_1005  = 20'h01005;
  localparam logic [19:0] E_40960 = 20'h40960;
  localparam logic [19:0] E_42    = 20'h00042;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        valid;
  logic [19:0] digits;
  logic        div_init;
  logic [15:0] div_op_A;
  logic [15:0] div_op_B;
  logic        div_done;
  logic [31:0] div_result;

  always #5 clk = ~clk;

  bcd_split_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .value      (value),
    .busy       (busy),
    .valid      (valid),
    .digits     (digits),
    .div_init   (div_init),
    .div_op_A   (div_op_A),
    .div_op_B   (div_op_B),
    .div_done   (div_done),
    .div_result (div_result)
  );

  // Divider model: data-dependent latency, done held high for several cycles, junk in upper result.
  logic [15:0] m_a;
  logic [15:0] m_b;
  int          m_cnt;
  int          m_hold;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      div_done   <= 1'b0;
      div_result <= '0;
      m_a        <= '0;
      m_b        <= 16'd1;
      m_cnt      <= 0;
      m_hold     <= 0;
    end else if (div_init) begin
      m_a      <= div_op_A;
      m_b      <= div_op_B;
      m_cnt    <= 3 + int'(div_op_A % 16'd4);
      div_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_done   <= 1'b1;
        div_result <= {16'hDEAD, m_a / m_b};
        m_hold     <= 6;
      end
    end else if (m_hold > 0) begin
      m_hold <= m_hold - 1;
      if (m_hold == 1) div_done <= 1'b0;
    end
  end

  logic [19:0] exp_dig_q[$];
  logic [15:0] exp_opa_q[$];
  int checks      = 0;
  int failures    = 0;
  int init_count  = 0;
  int valid_count = 0;
  bit check_busy_low = 1'b0;

  // Monitor: pops expectations whenever the DUT issues a division or presents a result.
  initial begin
    logic [15:0] eo;
    logic [19:0] ed;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (check_busy_low) begin
          checks++;
          if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_fall: busy=%b required 0 after valid", busy);
          end
          check_busy_low = 1'b0;
        end
        if (div_init) begin
          init_count++;
          checks++;
          if (div_done) begin
            failures++;
            $display("FAIL init_while_done: div_init asserted with div_done=1");
          end
          if (exp_opa_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_init: op_A=%0d with nothing expected", div_op_A);
          end else begin
            eo = exp_opa_q.pop_front();
            if (div_op_A !== eo || div_op_B !== 16'd10) begin
              failures++;
              $display("FAIL div_operands: op_A=%0d op_B=%0d required op_A=%0d op_B=10",
                       div_op_A, div_op_B, eo);
            end
          end
        end
        if (valid) begin
          valid_count++;
          checks++;
          check_busy_low = 1'b1;
          if (exp_dig_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid: digits=%h with nothing expected", digits);
          end else begin
            ed = exp_dig_q.pop_front();
            if (digits !== ed) begin
              failures++;
              $display("FAIL digits: got %h required %h", digits, ed);
            end
          end
        end
      end
    end
  end

  task automatic push_conv(input logic [15:0] v, input logic [19:0] e);
    logic [15:0] w;
    w = v;
    exp_dig_q.push_back(e);
    for (int i = 0; i < ND; i++) begin
      exp_opa_q.push_back(w);
      w = w / 16'd10;
    end
  endtask

  task automatic pulse_start(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise: busy=%b required 1 after start", busy);
    end
  endtask

  task automatic wait_idle(input logic [15:0] v);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      failures++;
      $display("FAIL timeout: conversion of %0d still busy after %0d cycles", v, n);
    end else begin
      $display("latency value=%0d cycles=%0d", v, n);
    end
  endtask

  task automatic wait_inits(input int target);
    for (int i = 0; i < 300 && init_count < target; i++) @(posedge clk);
    checks++;
    if (init_count < target) begin
      failures++;
      $display("FAIL init_wait: init_count=%0d required %0d", init_count, target);
    end
  endtask

  task automatic convert(input logic [15:0] v, input logic [19:0] e);
    int vc0;
    int ic0;
    vc0 = valid_count;
    ic0 = init_count;
    push_conv(v, e);
    pulse_start(v);
    wait_idle(v);
    repeat (2) @(posedge clk);
    checks++;
    if (valid_count != vc0 + 1 || init_count != ic0 + ND) begin
      failures++;
      $display("FAIL pulse_count value=%0d: valids=%0d inits=%0d required 1 and %0d",
               v, valid_count - vc0, init_count - ic0, ND);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int vc0;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || digits !== 20'h0 || div_init !== 1'b0 || div_op_A !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b valid=%b digits=%h init=%b op_A=%h required all 0",
               busy, valid, digits, div_init, div_op_A);
    end
    @(negedge clk);
    reset = 1'b0;

    convert(16'd12345, E_12345);
    convert(16'd65535, E_65535);
    convert(16'd0,     E_0);
    convert(16'd7,     E_7);
    convert(16'd40960, E_40960);
    convert(16'd1005,  E_1005);

    // A second start while busy must be dropped, not queued.
    vc0 = valid_count;
    push_conv(16'd12345, E_12345);
    pulse_start(16'd12345);
    wait_inits(init_count + 1);
    @(negedge clk);
    start = 1'b1;
    value = 16'd999;
    @(negedge clk);
    start = 1'b0;
    wait_idle(16'd12345);
    repeat (40) @(posedge clk);
    checks++;
    if (valid_count != vc0 + 1) begin
      failures++;
      $display("FAIL start_while_busy: valids=%0d required 1", valid_count - vc0);
    end

    // Reset during the third division clears everything immediately.
    vc0 = valid_count;
    push_conv(16'd54321, 20'h54321);
    pulse_start(16'd54321);
    wait_inits(init_count + 3);
    @(posedge clk);
    #2;
    exp_dig_q.delete();
    exp_opa_q.delete();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || digits !== 20'h0 || div_init !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b valid=%b digits=%h init=%b required 0 0 00000 0",
               busy, valid, digits, div_init);
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    checks++;
    if (valid_count != vc0) begin
      failures++;
      $display("FAIL mid_reset_valid: valids=%0d required 0", valid_count - vc0);
    end

    convert(16'd42, E_42);

    repeat (30) @(posedge clk);
    checks++;
    if (exp_dig_q.size() != 0 || exp_opa_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: digits_q=%0d opa_q=%0d required 0 0",
               exp_dig_q.size(), exp_opa_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_split_ctrl.md
Name: bcd_split_ctrl

Overview:
- Converts a 16-bit binary stopwatch count into NUM_DIGITS packed BCD digits for the display path.
- Performs repeated divide-by-DIVISOR through the shared sequential divider `div`, using its init/done handshake.
- Sits between the stopwatch counter (upstream) and the 7-segment mux (downstream), wrapped around `div`.
- The remainder is computed locally, because `div` returns only the quotient.

Parameters:
- NUM_DIGITS, 5: number of digits produced; 5 covers 0..65535.
- DIVISOR, 10: constant driven on div_op_B; must be at least 2 and at most 16 so each remainder fits in 4 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; value is sampled on the same edge
- value  in  16  binary count to convert
- busy  out  1  high from the cycle after an accepted start until valid
- valid  out  1  one-cycle pulse; digits are updated on that same cycle
- digits  out  4*NUM_DIGITS  packed BCD; digit 0 (least significant) is in [3:0]
- div_init  out  1  to div.init
- div_op_A  out  16  to div.op_A (current working value)
- div_op_B  out  16  to div.op_B; constant DIVISOR
- div_done  in  1  from div.done
- div_result  in  32  from div.result; the quotient is [15:0], bits [31:16] are ignored

Behaviour:
- Reset values: busy=0, valid=0, digits=0, div_init=0, div_op_A=0, digit index k=0, work=0, FSM=IDLE. `div` shares the same reset.
- IDLE:
  - start=1 latches work<=value, sets k<=0, busy<=1, then goes to DRAIN.
  - start is ignored in every other state; a start during busy is lost, not queued.
- DRAIN:
  - Waits while div_done=1. The divider holds done high for many cycles after each result, so issuing early would not be seen.
  - On div_done=0, goes to ISSUE.
- ISSUE:
  - div_op_A=work and div_init=1 for exactly one cycle, then goes to WAIT.
  - div_op_A stays stable at work from ISSUE until div_done rises.
- WAIT:
  - Registers div_done into done_q.
  - A rising edge (div_done=1 and done_q=0) captures q=div_result[15:0] and goes to STORE.
- STORE:
  - rem = work - q*DIVISOR, computed in 16 bits. For DIVISOR=10, q*10 = (q<<3)+(q<<1).
  - digit[k] <= rem[3:0]; work <= q.
  - If k==NUM_DIGITS-1: goes to DONE. Otherwise k<=k+1 and goes to DRAIN.
- DONE: valid=1 for one cycle, busy<=0, returns to IDLE.
- Fixed work:
  - Exactly NUM_DIGITS divisions per conversion, including when value=0. There is no early exit.
  - Any quotient left in work after the last digit (value ≥ 10^NUM_DIGITS) is discarded.
- Digit register timing: all digits update together. Per-digit results are built in a shadow register and copied to digits at the DONE cycle, so digits never show a partial conversion.
- Reset mid-conversion: everything returns to reset values immediately; no valid pulse is produced. digits return to 0.
- Latency: data-dependent only on the divider's timing. The bench measures it; it is not fixed by this spec.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when copying to digits, each zero digit above the most significant nonzero digit is replaced by 4'hF (blank code for the 7-seg mux). Digit 0 is never blanked, so value 0 gives 0xF..F0.
- Undefined: raw BCD output with leading zeros.
- In both cases busy/valid timing is identical.

Test Plan:
- value=12345, start pulse -> exactly 5 div_init pulses, each with div_op_B=10. div_op_A sequence is 12345, 1234, 123, 12, 1. valid once; digits=20'h12345; busy falls with valid.
- value=65535 -> digits=20'h65535. value=0 -> digits=20'h00000 (macro off) or 20'hFFFF0 (macro on).
- value=7 with LEADING_ZERO_BLANK_EN -> digits=20'hFFFF7. value=1005 -> 20'hF1005.
- Second start pulse asserted mid-conversion (value=999) -> ignored; only one valid, with the digits of the first value.
- div_init is never asserted while div_done=1. After each capture there is a DRAIN wait until div_done=0 before the next ISSUE, checked by assertion.
- reset asserted during the 3rd division -> busy=0, valid=0, digits=0 immediately. A new start with value=42 then gives 20'h00042 and a normal single valid.
